// File: rtl/bram_sort_drain_if.sv
// Bus bundle for bram_sort_drain: the single-port RAM read port plus the
// valid/ready output stream.
//   master (the drain block): drives ram_cs/ram_oe/ram_we/ram_address and
//                             m_data/m_valid/m_last; receives ram_dout, m_ready.
//   slave  (RAM + consumer):  the reverse directions.
interface bram_sort_drain_if #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDRESS_WIDTH = 8
) ();
  logic                     ram_cs;
  logic                     ram_oe;
  logic                     ram_we;
  logic [ADDRESS_WIDTH-1:0] ram_address;
  logic [DATA_WIDTH-1:0]    ram_dout;
  logic [DATA_WIDTH-1:0]    m_data;
  logic                     m_valid;
  logic                     m_ready;
  logic                     m_last;

  modport master (
    output ram_cs, ram_oe, ram_we, ram_address, m_data, m_valid, m_last,
    input  ram_dout, m_ready
  );

  modport slave (
    input  ram_cs, ram_oe, ram_we, ram_address, m_data, m_valid, m_last,
    output ram_dout, m_ready
  );
endinterface

// File: rtl/bram_sort_drain.sv
// Read-out stage behind the sorting RAM. A start pulse walks addresses
// 0..DEPTH-1, captures each word into a small FIFO that feeds a valid/ready
// stream, and raises a sticky flag if any word is smaller than the previous.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - one-cycle pass request (ignored while busy)
//   busy        - pass in progress
//   done        - one-cycle pulse once the last word has been popped
//   order_err   - sticky: words of the current/last pass were out of order
//   bus         - RAM read port and output stream (master side)
module bram_sort_drain #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               order_err,
  bram_sort_drain_if.master  bus
);

  localparam int unsigned FifoAw = $clog2(FIFO_DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] LastAddr = ADDRESS_WIDTH'(DEPTH - 1);
  localparam logic [FifoAw:0] FifoFull = (FifoAw + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StIssue, StCapture, StDrain, StFinish} state_e;

  state_e r_state, w_state_next;

  logic [ADDRESS_WIDTH-1:0] r_ptr;
  logic [DATA_WIDTH-1:0]    r_fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]    r_fifo_last;
  logic [FifoAw-1:0]        r_wr_idx;
  logic [FifoAw-1:0]        r_rd_idx;
  logic [FifoAw:0]          r_count;
  logic [DATA_WIDTH-1:0]    r_prev;
  logic                     r_have_prev;
  logic                     r_order_err;

  logic w_start;
  logic w_push;
  logic w_pop;
  logic w_valid;
  logic w_full;
  logic w_is_last;

  assign w_valid   = (r_count != '0);
  assign w_full    = (r_count == FifoFull);
  assign w_is_last = (r_ptr == LastAddr);
  assign w_start   = (r_state == StIdle) && start;
  assign w_push    = (r_state == StCapture);
  assign w_pop     = w_valid && bus.m_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; ISSUE only looks at the registered count, so a pop in
  // the same cycle unblocks a full FIFO one cycle later.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (start) w_state_next = StIssue;
      StIssue:   if (!w_full) w_state_next = StCapture;
      StCapture: w_state_next = w_is_last ? StDrain : StIssue;
      StDrain:   if (r_count == '0) w_state_next = StFinish;
      StFinish:  w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  // Read pointer and order checker. The pointer stops at the last address so
  // ram_address keeps its final value after the pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_prev      <= '0;
      r_have_prev <= 1'b0;
      r_order_err <= 1'b0;
    end else if (w_start) begin
      r_ptr       <= '0;
      r_have_prev <= 1'b0;
      r_order_err <= 1'b0;
    end else if (w_push) begin
      if (r_have_prev && (bus.ram_dout < r_prev)) begin
        r_order_err <= 1'b1;
      end
      r_prev      <= bus.ram_dout;
      r_have_prev <= 1'b1;
      if (!w_is_last) begin
        r_ptr <= r_ptr + 1'b1;
      end
    end
  end

  // Output FIFO. Storage is reset so m_data reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_data[i] <= '0;
      end
      r_fifo_last <= '0;
      r_wr_idx    <= '0;
      r_rd_idx    <= '0;
      r_count     <= '0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_idx] <= bus.ram_dout;
        r_fifo_last[r_wr_idx] <= w_is_last;
        r_wr_idx              <= r_wr_idx + 1'b1;
      end
      if (w_pop) begin
        r_rd_idx <= r_rd_idx + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign busy            = (r_state != StIdle);
  assign done            = (r_state == StFinish);
  assign order_err       = r_order_err;
  assign bus.ram_cs      = (r_state == StIssue) || (r_state == StCapture);
  assign bus.ram_oe      = (r_state == StIssue) || (r_state == StCapture);
  assign bus.ram_we      = 1'b0;
  assign bus.ram_address = r_ptr;
  assign bus.m_valid     = w_valid;
  assign bus.m_data      = r_fifo_data[r_rd_idx];
  assign bus.m_last      = w_valid && r_fifo_last[r_rd_idx];

endmodule
